// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered N_CH:1 multiplexer with MANUAL and SCAN modes.
//
// Ports
//   iClk    in   1        clock, rising edge
//   iRst_n  in   1        asynchronous reset, active-low
//   iData   in   N_CH*W   packed channel data, channel k = iData[k*W +: W]
//   iSel    in   SEL_W    channel index, sampled when iLoad is high
//   iLoad   in   1        one-cycle select strobe
//   iMode   in   1        0 = MANUAL, 1 = SCAN
//   iEn     in   1        block enable
//   oY      out  W        registered selected data
//   oCh     out  SEL_W    current channel register
//   oValid  out  1        oY holds a sample captured on the previous edge
//   oWrap   out  1        one-cycle pulse when SCAN wraps N_CH-1 -> 0
//   oErr    out  1        one-cycle pulse on an out-of-range iSel load
//   oState  out  2        current FSM state (0 IDLE, 1 MANUAL, 2 SCAN), for debug
//
// Handshake: iLoad is a single-cycle strobe with no back-pressure; it acts
// only while the block is enabled and not in IDLE. oValid qualifies oY for
// exactly the cycle after each capture edge; there is no ready input.
module mux_scan_sel #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [N_CH*W-1:0]   iData,
  input  logic [SEL_W-1:0]    iSel,
  input  logic                iLoad,
  input  logic                iMode,
  input  logic                iEn,
  output logic [W-1:0]        oY,
  output logic [SEL_W-1:0]    oCh,
  output logic                oValid,
  output logic                oWrap,
  output logic                oErr,
  output logic [1:0]          oState
);

  // Counter is at least one bit wide so DWELL=1 still elaborates.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(N_CH - 1);
  // One extra bit so the range check also works when N_CH is a power of two.
  localparam logic [SEL_W:0]   N_CH_V     = (SEL_W + 1)'(N_CH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [SEL_W-1:0] ch_d;
  logic [W-1:0]     y_d;
  logic             valid_d, wrap_d, err_d;
  logic             active, sel_ok;

  assign oState = state;
  assign active = (state != IDLE) && iEn;
  assign sel_ok = ({1'b0, iSel} < N_CH_V);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ch_d    = oCh;
    y_d     = oY;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;

    case (state)
      IDLE:    if (iEn) state_d = iMode ? SCAN : MANUAL;
      default: state_d = !iEn ? IDLE : (iMode ? SCAN : MANUAL);
    endcase

    // Capture from the channel held at this edge; a new oCh shows up in oY one edge later.
    if (state != IDLE) begin
      y_d     = iData[oCh*W +: W];
      valid_d = 1'b1;
    end

    if (active) begin
      if (iLoad && sel_ok) begin
        // A valid load beats a coincident dwell expiry: no increment, no wrap.
        ch_d  = iSel;
        cnt_d = '0;
      end else if (state == SCAN && state_d == SCAN) begin
        if (cnt == DWELL_LAST) begin
          cnt_d = '0;
          if (oCh == CH_LAST) begin
            ch_d   = '0;
            wrap_d = 1'b1;
          end else begin
            ch_d = oCh + SEL_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      if (iLoad && !sel_ok) err_d = 1'b1;
    end

    if (state_d != state) cnt_d = '0;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      oCh    <= '0;
      oY     <= '0;
      oValid <= 1'b0;
      oWrap  <= 1'b0;
      oErr   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      oCh    <= ch_d;
      oY     <= y_d;
      oValid <= valid_d;
      oWrap  <= wrap_d;
      oErr   <= err_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
module tb_mux_scan_sel;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  logic [31:0] data8;
  logic [23:0] data6;
  logic [2:0]  sel;
  logic        load, mode, en;

  logic [3:0] y8, y6;
  logic [2:0] ch8, ch6;
  logic       valid8, wrap8, err8, valid6, wrap6, err6;
  logic [1:0] st8, st6;

  int checks = 0;
  int errors = 0;

  mux_scan_sel #(.N_CH(8), .W(W), .DWELL(2)) dut8 (
    .iClk(iClk), .iRst_n(iRst_n), .iData(data8), .iSel(sel), .iLoad(load),
    .iMode(mode), .iEn(en), .oY(y8), .oCh(ch8), .oValid(valid8),
    .oWrap(wrap8), .oErr(err8), .oState(st8)
  );

  mux_scan_sel #(.N_CH(6), .W(W), .DWELL(2)) dut6 (
    .iClk(iClk), .iRst_n(iRst_n), .iData(data6), .iSel(sel), .iLoad(load),
    .iMode(mode), .iEn(en), .oY(y6), .oCh(ch6), .oValid(valid6),
    .oWrap(wrap6), .oErr(err6), .oState(st6)
  );

  // ---------------- driver tasks ----------------
  task automatic set_default_data();
    for (int k = 0; k < 8; k++) data8[k*W +: W] = 4'(k + 3);
    for (int k = 0; k < 6; k++) data6[k*W +: W] = 4'(k + 3);
  endtask

  task automatic apply_reset();
    @(negedge iClk);
    iRst_n = 1'b0;
    load = 1'b0; sel = '0; mode = 1'b0; en = 1'b0;
    set_default_data();
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  // Advance one active edge and settle before sampling.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Drive at the falling edge, then step over the next rising edge.
  task automatic drive_tick(input logic l, input logic [2:0] s, input logic m, input logic e);
    @(negedge iClk);
    load = l; sel = s; mode = m; en = e;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (y8 !== 4'd0)   begin errors++; $display("FAIL reset_y got %0d want 0", y8); end
    checks++; if (ch8 !== 3'd0)  begin errors++; $display("FAIL reset_ch got %0d want 0", ch8); end
    checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid8); end
    checks++; if (wrap8 !== 1'b0 || err8 !== 1'b0) begin errors++; $display("FAIL reset_flags wrap=%b err=%b want 0 0", wrap8, err8); end
    checks++; if (st8 !== 2'd0)  begin errors++; $display("FAIL reset_state got %0d want 0", st8); end
    checks++; if (y6 !== 4'd0 || ch6 !== 3'd0 || valid6 !== 1'b0) begin errors++; $display("FAIL reset_n6 y=%0d ch=%0d v=%b want 0 0 0", y6, ch6, valid6); end
  endtask

  task automatic test_manual();
    apply_reset();
    drive_tick(1'b0, 3'd0, 1'b0, 1'b1);            // IDLE -> MANUAL
    checks++; if (st8 !== 2'd1) begin errors++; $display("FAIL manual_state got %0d want 1", st8); end
    drive_tick(1'b1, 3'd5, 1'b0, 1'b1);            // load 5 at edge k
    checks++; if (ch8 !== 3'd5) begin errors++; $display("FAIL manual_ch got %0d want 5", ch8); end
    checks++; if (y8 !== 4'd3) begin errors++; $display("FAIL manual_y_k got %0d want 3", y8); end
    drive_tick(1'b0, 3'd0, 1'b0, 1'b1);            // edge k+1
    checks++; if (y8 !== 4'd8 || valid8 !== 1'b1) begin errors++; $display("FAIL manual_y_k1 got y=%0d v=%b want 8 1", y8, valid8); end
  endtask

  task automatic test_scan_wrap();
    logic [2:0] exp_ch [7];
    logic       exp_wrap [7];
    exp_ch   = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1};
    exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    drive_tick(1'b0, 3'd0, 1'b0, 1'b1);
    drive_tick(1'b1, 3'd6, 1'b0, 1'b1);
    drive_tick(1'b0, 3'd0, 1'b1, 1'b1);            // MANUAL -> SCAN, dwell cleared
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      checks++;
      if (ch8 !== exp_ch[i] || wrap8 !== exp_wrap[i]) begin
        errors++;
        $display("FAIL scan_seq[%0d] got ch=%0d wrap=%b want ch=%0d wrap=%b", i, ch8, wrap8, exp_ch[i], exp_wrap[i]);
      end
    end
    // Asynchronous reset between edges while scanning.
    #2;
    iRst_n = 1'b0;
    #1;
    checks++; if (y8 !== 4'd0 || ch8 !== 3'd0) begin errors++; $display("FAIL async_reset_data y=%0d ch=%0d want 0 0", y8, ch8); end
    checks++; if (valid8 !== 1'b0 || wrap8 !== 1'b0 || st8 !== 2'd0) begin errors++; $display("FAIL async_reset_ctrl v=%b wrap=%b st=%0d want 0 0 0", valid8, wrap8, st8); end
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  task automatic test_load_vs_expiry();
    apply_reset();
    drive_tick(1'b0, 3'd0, 1'b0, 1'b1);
    drive_tick(1'b1, 3'd7, 1'b0, 1'b1);
    drive_tick(1'b0, 3'd0, 1'b1, 1'b1);            // SCAN, oCh=7, dwell 0
    drive_tick(1'b0, 3'd0, 1'b1, 1'b1);            // dwell 1, next edge expires
    checks++; if (ch8 !== 3'd7) begin errors++; $display("FAIL lvx_pre got ch=%0d want 7", ch8); end
    drive_tick(1'b1, 3'd2, 1'b1, 1'b1);            // load coincides with expiry
    checks++; if (ch8 !== 3'd2 || wrap8 !== 1'b0) begin errors++; $display("FAIL lvx_load got ch=%0d wrap=%b want 2 0", ch8, wrap8); end
    drive_tick(1'b0, 3'd0, 1'b1, 1'b1);
    checks++; if (ch8 !== 3'd2 || wrap8 !== 1'b0) begin errors++; $display("FAIL lvx_dwell got ch=%0d wrap=%b want 2 0", ch8, wrap8); end
    drive_tick(1'b0, 3'd0, 1'b1, 1'b1);
    checks++; if (ch8 !== 3'd3) begin errors++; $display("FAIL lvx_adv got ch=%0d want 3", ch8); end
    // Load while enable drops: goes to IDLE, load ignored, no error.
    drive_tick(1'b1, 3'd6, 1'b1, 1'b0);
    checks++; if (ch8 !== 3'd3 || st8 !== 2'd0) begin errors++; $display("FAIL load_disable got ch=%0d st=%0d want 3 0", ch8, st8); end
    drive_tick(1'b1, 3'd7, 1'b0, 1'b0);            // out-of-range load for N_CH=6 while IDLE
    checks++; if (err6 !== 1'b0) begin errors++; $display("FAIL idle_load_err got %b want 0", err6); end
  endtask

  task automatic test_range_error();
    apply_reset();
    drive_tick(1'b0, 3'd0, 1'b0, 1'b1);
    drive_tick(1'b1, 3'd4, 1'b0, 1'b1);
    drive_tick(1'b0, 3'd0, 1'b0, 1'b1);
    checks++; if (ch6 !== 3'd4 || y6 !== 4'd7) begin errors++; $display("FAIL err_setup got ch=%0d y=%0d want 4 7", ch6, y6); end
    drive_tick(1'b1, 3'd7, 1'b0, 1'b1);
    checks++; if (err6 !== 1'b1) begin errors++; $display("FAIL err_pulse got %b want 1", err6); end
    checks++; if (ch6 !== 3'd4 || y6 !== 4'd7) begin errors++; $display("FAIL err_hold got ch=%0d y=%0d want 4 7", ch6, y6); end
    checks++; if (err8 !== 1'b0 || ch8 !== 3'd7) begin errors++; $display("FAIL err_n8 got err=%b ch=%0d want 0 7", err8, ch8); end
    drive_tick(1'b0, 3'd0, 1'b0, 1'b1);
    checks++; if (err6 !== 1'b0 || ch6 !== 3'd4 || y6 !== 4'd7) begin errors++; $display("FAIL err_after got err=%b ch=%0d y=%0d want 0 4 7", err6, ch6, y6); end
  endtask

  task automatic test_manual_sweep();
    logic [3:0] exp_y;
    logic [3:0] held;
    apply_reset();
    drive_tick(1'b0, 3'd0, 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      drive_tick(1'b1, 3'(c), 1'b0, 1'b1);
      checks++; if (ch8 !== 3'(c)) begin errors++; $display("FAIL sweep_ch got %0d want %0d", ch8, c); end
      for (int p = 0; p < 16; p++) begin
        @(negedge iClk);
        load = 1'b0;
        data8 = $urandom;
        exp_y = data8[c*W +: W];
        tick();
        checks++;
        if (y8 !== exp_y || valid8 !== 1'b1) begin
          errors++;
          $display("FAIL sweep_y ch=%0d pat=%0d got y=%0d v=%b want y=%0d v=1", c, p, y8, valid8, exp_y);
        end
      end
    end
    // Disable: the edge leaving MANUAL still captures, IDLE then holds.
    @(negedge iClk);
    en = 1'b0;
    data8 = $urandom;
    held = data8[7*W +: W];
    tick();
    checks++; if (y8 !== held || st8 !== 2'd0) begin errors++; $display("FAIL disable_edge got y=%0d st=%0d want %0d 0", y8, st8, held); end
    for (int i = 0; i < 2; i++) begin
      @(negedge iClk);
      data8 = ~data8;
      tick();
      checks++; if (y8 !== held || valid8 !== 1'b0) begin errors++; $display("FAIL idle_hold got y=%0d v=%b want %0d 0", y8, valid8, held); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    load = 1'b0; sel = '0; mode = 1'b0; en = 1'b0;
    set_default_data();
    test_reset();
    test_manual();
    test_scan_wrap();
    test_load_vs_expiry();
    test_range_error();
    test_manual_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
